// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between an icache and a dcache.
// At most one memory transaction is in flight; responses are routed back to the granted port.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // icache port
  input  logic [ADDR_W-1:0]   icache_addr,
  input  logic                icache_re,
  output logic [DATA_W-1:0]   icache_dout,
  output logic                icache_dout_val,
  output logic                icache_stall,
  // dcache port
  input  logic [ADDR_W-1:0]   dcache_addr,
  input  logic                dcache_re,
  input  logic [DATA_W-1:0]   dcache_din,
  input  logic [DATA_W/8-1:0] dcache_we,
  output logic [DATA_W-1:0]   dcache_dout,
  output logic                dcache_dout_val,
  output logic                dcache_stall,
  // memory request
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  input  logic                mem_ready,
  // memory response
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;            // 1 = dcache owns the transaction
  logic                last_grant_q, last_grant_d;  // 1 = dcache was served last
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     we_q, we_d;
  logic [DATA_W-1:0]   idout_q, ddout_q;

  logic i_req, d_req, rsp;

  assign i_req = icache_re;
  assign d_req = dcache_re | (|dcache_we);
  // A response arriving while reset is asserted belongs to an abandoned transaction.
  assign rsp   = (state_q == WAIT) && mem_rvalid && !rst;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // dcache wins when alone, or on a tie when icache was served last
          grant_d = d_req && (!i_req || !last_grant_q);
          addr_d  = grant_d ? dcache_addr : icache_addr;
          wdata_d = grant_d ? dcache_din : '0;
          we_d    = grant_d ? dcache_we : '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= '0;
      idout_q      <= '0;
      ddout_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if (rsp && !grant_q) idout_q <= mem_rdata;
      if (rsp && grant_q)  ddout_q <= mem_rdata;
    end
  end

  assign mem_valid       = (state_q == ISSUE);
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_we          = we_q;

  assign icache_dout_val = rsp && !grant_q;
  assign dcache_dout_val = rsp && grant_q;
  assign icache_dout     = icache_dout_val ? mem_rdata : idout_q;
  assign dcache_dout     = dcache_dout_val ? mem_rdata : ddout_q;
  assign icache_stall    = i_req && !icache_dout_val;
  assign dcache_stall    = d_req && !dcache_dout_val;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all ports; DATA_W/8 byte lanes.
REQ-003 SHALL have ports: clk input 1, the single clock; rst input 1, reset that is synchronous and active-high.
REQ-004 SHALL have icache ports: icache_addr input ADDR_W, fetch address; icache_re input 1, fetch request.
REQ-005 SHALL have icache ports: icache_dout output DATA_W, fetch data; icache_dout_val output 1, one-cycle response pulse; icache_stall output 1, request pending.
REQ-006 SHALL have dcache ports: dcache_addr input ADDR_W, access address; dcache_re input 1, load request.
REQ-007 SHALL have dcache ports: dcache_din input DATA_W, store data; dcache_we input DATA_W/8, store byte enables, nonzero means store.
REQ-008 SHALL have dcache ports: dcache_dout output DATA_W, load data; dcache_dout_val output 1, one-cycle response/store-ack pulse; dcache_stall output 1, request pending.
REQ-009 SHALL have memory request ports: mem_valid output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_we output DATA_W/8 (0 means read), mem_ready input 1 (accept).
REQ-010 SHALL have memory response ports: mem_rvalid input 1, response; mem_rdata input DATA_W, read data.

Function
REQ-011 SHALL share one single-ported memory between icache and dcache, with at most one transaction outstanding.
REQ-012 SHALL have FSM states IDLE, ISSUE, WAIT.
REQ-013 In IDLE, with any request (icache_re, dcache_re, or dcache_we!=0), SHALL register grant, address, wdata, we, then go to ISSUE; no request means stay in IDLE.
REQ-014 With both ports requesting in IDLE, SHALL grant the port not granted last (round-robin, last_grant bit); a sole requester is always granted.
REQ-015 A dcache request with dcache_we!=0 SHALL be a store even if dcache_re=1; icache requests SHALL always be reads (mem_we=0).
REQ-016 In ISSUE, SHALL drive mem_valid=1 with registered mem_addr/mem_wdata/mem_we held stable; on mem_ready=1 SHALL go to WAIT.
REQ-017 mem_valid SHALL be 0 in IDLE and WAIT.
REQ-018 In WAIT, on mem_rvalid=1, SHALL pulse the granted port's dout_val for exactly that cycle, drive that port's dout=mem_rdata, update last_grant, and return to IDLE.
REQ-019 Stores SHALL also complete via mem_rvalid; dcache_dout_val pulses as ack and dcache_dout is don't-care.
REQ-020 dout of the non-granted port SHALL hold its previous value; dout_val of the non-granted port SHALL be 0.
REQ-021 mem_rvalid outside WAIT SHALL be ignored.
REQ-022 Requester contract: addr/din/we/re are held stable from assertion through the dout_val cycle; inputs seen in the first IDLE cycle after dout_val are a new request.
REQ-023 Minimum latency: with mem_ready=1 in ISSUE and mem_rvalid=1 in the first WAIT cycle, a request sampled in IDLE at cycle 0 gets dout_val at cycle 2; back-to-back throughput is one transaction per 3 cycles.
REQ-024 Each port's stall SHALL be combinational: (that port's request) AND NOT (that port's dout_val).

Reset
REQ-025 When rst=1 at a clock edge, SHALL enter IDLE, set last_grant=icache (dcache wins first tie), and clear mem_valid, both dout_val, both dout, mem_addr, mem_wdata, mem_we.
REQ-026 Reset asserted mid-transaction (ISSUE or WAIT) SHALL abandon it without a dout_val pulse; a late mem_rvalid SHALL be ignored per REQ-021.

Verification
REQ-027 Reset, then icache_re=1, addr=0x100, mem_ready=1, mem_rvalid=1 next cycle with rdata=0xDEADBEEF -> mem_valid at cycle 1 with mem_addr=0x100, mem_we=0; icache_dout=0xDEADBEEF and icache_dout_val=1 at cycle 2 only.
REQ-028 Both ports requesting after reset -> dcache served first, then icache, then dcache; grants alternate while both are held.
REQ-029 dcache_we=4'b0011, dcache_re=1, din=0x1234ABCD, addr=0x200 -> mem_we=4'b0011, mem_wdata=0x1234ABCD; dcache_dout_val pulses on mem_rvalid.
REQ-030 mem_ready held 0 for 5 cycles in ISSUE -> mem_valid and mem_addr stable for 5 cycles, stall stays 1, no dout_val.
REQ-031 rst pulsed while in WAIT, then mem_rvalid=1 -> no dout_val pulse, FSM in IDLE, mem_valid=0.
